// File: rtl/alarm_arm_controller_pkg.sv
// rtl/alarm_arm_controller_pkg.sv - shared state encodings, code width and helpers
package alarm_arm_controller_pkg;

  localparam int CODE_W = 10;
  localparam logic [CODE_W-1:0] DEFAULT_CODE = 10'h112;

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_EXIT     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_ALARM    = 3'd3,
    ST_LOCKOUT  = 3'd4
  } state_t;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int cnt_width(input longint unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alarm_arm_controller_sync_debounce.sv
// rtl/alarm_arm_controller_sync_debounce.sv - 2-FF synchronizer plus level debouncer with change event
module alarm_arm_controller_sync_debounce
  import alarm_arm_controller_pkg::*;
#(
  parameter int unsigned DEB_CYC   = 500_000,
  parameter bit          RISE_ONLY = 1'b0
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic iAsync,
  output logic oLevel,
  output logic oEvt
);

  localparam int CW = cnt_width(longint'(DEB_CYC));

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic [1:0]    fill;

  // The first three edges after reset just copy the synced level so the
  // debounced value starts equal to the input and no edge is reported.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      oLevel <= 1'b0;
      oEvt   <= 1'b0;
      cnt    <= '0;
      fill   <= 2'd0;
    end else begin
      s1   <= iAsync;
      s2   <= s1;
      oEvt <= 1'b0;
      if (fill != 2'd3) begin
        fill   <= fill + 2'd1;
        oLevel <= s2;
        cnt    <= '0;
      end else if (s2 == oLevel) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYC - 1)) begin
        oLevel <= s2;
        cnt    <= '0;
        oEvt   <= RISE_ONLY ? s2 : 1'b1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alarm_arm_controller.sv
// rtl/alarm_arm_controller.sv - arm/alarm FSM with code register, shared timer and beep divider
module alarm_arm_controller
  import alarm_arm_controller_pkg::*;
#(
  parameter logic [CODE_W-1:0] DEFAULT_CODE_P = DEFAULT_CODE,
  parameter int unsigned       DEB_CYC        = 500_000,
  parameter longint unsigned   EXIT_CYC       = 64'd500_000_000,
  parameter int unsigned       BEEP_HALF      = 12_500_000,
  parameter int unsigned       MAX_FAIL       = 3,
  parameter longint unsigned   LOCKOUT_CYC    = 64'd5_000_000_000
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic [CODE_W-1:0] iCode,
  input  logic              iProgram,
  input  logic              iArm,
  input  logic              iSubmit,
  input  logic              iSense,
  output logic              oVideo_On,
  output logic              oBuzzer,
  output logic [2:0]        oState,
  output logic [2:0]        oFail_Cnt
);

  localparam longint unsigned TMAX = (EXIT_CYC > LOCKOUT_CYC) ? EXIT_CYC : LOCKOUT_CYC;
  localparam int TW = cnt_width(TMAX);
  localparam int BW = cnt_width(longint'(BEEP_HALF));

  logic prog_evt, arm_evt, sub_evt, sense_evt;
  logic prog_lvl, arm_lvl, sub_lvl, sense_lvl;
  logic unused_levels;

  alarm_arm_controller_sync_debounce #(.DEB_CYC(DEB_CYC), .RISE_ONLY(1'b0)) u_sense (
    .iCLK(iCLK), .iRST_N(iRST_N), .iAsync(iSense), .oLevel(sense_lvl), .oEvt(sense_evt)
  );
  alarm_arm_controller_sync_debounce #(.DEB_CYC(1), .RISE_ONLY(1'b1)) u_prog (
    .iCLK(iCLK), .iRST_N(iRST_N), .iAsync(iProgram), .oLevel(prog_lvl), .oEvt(prog_evt)
  );
  alarm_arm_controller_sync_debounce #(.DEB_CYC(1), .RISE_ONLY(1'b1)) u_arm (
    .iCLK(iCLK), .iRST_N(iRST_N), .iAsync(iArm), .oLevel(arm_lvl), .oEvt(arm_evt)
  );
  alarm_arm_controller_sync_debounce #(.DEB_CYC(1), .RISE_ONLY(1'b1)) u_sub (
    .iCLK(iCLK), .iRST_N(iRST_N), .iAsync(iSubmit), .oLevel(sub_lvl), .oEvt(sub_evt)
  );

  assign unused_levels = ^{prog_lvl, arm_lvl, sub_lvl, sense_lvl};

  state_t            state, state_n;
  logic [TW-1:0]     timer, timer_n;
  logic [2:0]        fail, fail_n;
  logic [CODE_W-1:0] code, code_n;
  logic [BW-1:0]     beep, beep_n;
  logic              buzz, buzz_n;
  logic              video, video_n;
  logic              code_ok;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= ST_DISARMED;
      timer <= '0;
      fail  <= '0;
      code  <= DEFAULT_CODE_P;
      beep  <= '0;
      buzz  <= 1'b0;
      video <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      fail  <= fail_n;
      code  <= code_n;
      beep  <= beep_n;
      buzz  <= buzz_n;
      video <= video_n;
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    fail_n  = fail;
    code_n  = code;
    beep_n  = '0;
    buzz_n  = 1'b0;
    video_n = 1'b0;
    code_ok = (iCode == code);

    case (state)
      ST_DISARMED: begin
        timer_n = '0;
        // Program takes priority; a simultaneous arm is dropped.
        if (prog_evt) begin
          code_n = iCode;
        end else if (arm_evt && (iCode == '0)) begin
          state_n = ST_EXIT;
        end
      end
      ST_EXIT, ST_ARMED, ST_ALARM: begin
        if (state == ST_EXIT) begin
          if (timer == TW'(EXIT_CYC - 1)) begin
            state_n = ST_ARMED;
            timer_n = '0;
          end else begin
            timer_n = timer + TW'(1);
          end
        end else if ((state == ST_ARMED) && sense_evt) begin
          state_n = ST_ALARM;
        end
        // Submits are evaluated last so a correct code beats a same-cycle sense event.
        if (sub_evt) begin
          if (code_ok) begin
            state_n = ST_DISARMED;
            fail_n  = '0;
            timer_n = '0;
          end else begin
            fail_n = (fail == 3'(MAX_FAIL)) ? fail : fail + 3'd1;
            if (fail_n == 3'(MAX_FAIL)) begin
              state_n = ST_LOCKOUT;
              timer_n = '0;
            end
          end
        end
      end
      ST_LOCKOUT: begin
        if (timer == TW'(LOCKOUT_CYC - 1)) begin
          state_n = ST_ALARM;
          fail_n  = '0;
          timer_n = '0;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      default: begin
        state_n = ST_DISARMED;
        fail_n  = '0;
        timer_n = '0;
      end
    endcase

    video_n = (state_n == ST_ALARM) || (state_n == ST_LOCKOUT);

    if (state_n == ST_ALARM) begin
      if (state != ST_ALARM) begin
        buzz_n = 1'b1;
      end else if (beep == BW'(BEEP_HALF - 1)) begin
        buzz_n = ~buzz;
      end else begin
        buzz_n = buzz;
        beep_n = beep + BW'(1);
      end
    end else if (state_n == ST_LOCKOUT) begin
      buzz_n = 1'b1;
    end
  end

  assign oState    = state;
  assign oFail_Cnt = fail;
  assign oBuzzer   = buzz;
  assign oVideo_On = video;

endmodule
